// File: rtl/cond_pkg.sv
// ---------------------------------------------------------------------------
// cond_pkg
// Shared types for the flag/condition logic.
//   cond_e     : ARM 4-bit condition code (EQ..NV)
//   nzcv_t     : architectural flags, packed {n,z,c,v} (n is the MSB)
//   NZCV_RESET : default reset value of the flag register
// ---------------------------------------------------------------------------
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam logic [3:0] NZCV_RESET = 4'b0000;

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational evaluation of an ARM condition code against a set of
// flags. Shared by B.cond and the conditional-select datapath.
//   i_flags : flags {n,z,c,v}
//   i_cond  : condition code
//   o_taken : 1 when the condition holds (AL and NV always hold)
// ---------------------------------------------------------------------------
module cond_eval
    import cond_pkg::*;
(
    input  nzcv_t i_flags,
    input  cond_e i_cond,
    output logic  o_taken
);

    logic w_n_eq_v;

    assign w_n_eq_v = (i_flags.n == i_flags.v);

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_EQ: o_taken = i_flags.z;
            COND_NE: o_taken = !i_flags.z;
            COND_HS: o_taken = i_flags.c;
            COND_LO: o_taken = !i_flags.c;
            COND_MI: o_taken = i_flags.n;
            COND_PL: o_taken = !i_flags.n;
            COND_VS: o_taken = i_flags.v;
            COND_VC: o_taken = !i_flags.v;
            COND_HI: o_taken = i_flags.c && !i_flags.z;
            COND_LS: o_taken = !i_flags.c || i_flags.z;
            COND_GE: o_taken = w_n_eq_v;
            COND_LT: o_taken = !w_n_eq_v;
            COND_GT: o_taken = !i_flags.z && w_n_eq_v;
            COND_LE: o_taken = i_flags.z || !w_n_eq_v;
            COND_AL: o_taken = 1'b1;
            COND_NV: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// ---------------------------------------------------------------------------
// flag_cond_unit
// Captures ALU flags into the architectural NZCV register and produces a
// registered branch-taken decision for B.cond requests (1-cycle latency).
//   clk, reset       : clock (rising edge), asynchronous active-high reset
//   write_flags_i    : ALU flag-write strobe, flags on negative_i/zero_flag_i/
//                      carry_i/overflow_i
//   stall_i          : freezes NZCV and the decision registers
//   flush_i          : cancels the request presented this cycle
//   cond_valid_i     : evaluation request, cond_i = condition code
//   nzcv_o           : stored {N,Z,C,V}
//   taken_valid_o    : decision valid (held while stalled)
//   branch_taken_o   : decision, meaningful when taken_valid_o=1
//   cond_err_o       : sticky, set by an accepted NV (4'b1111) request
// Parameters:
//   BYPASS     : 1 = a request in a flag-write cycle sees the incoming flags
//   RESET_NZCV : reset value of the NZCV register
// ---------------------------------------------------------------------------
module flag_cond_unit
    import cond_pkg::*;
#(
    parameter bit         BYPASS     = 1'b1,
    parameter logic [3:0] RESET_NZCV = NZCV_RESET
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_flags_i,
    input  logic       negative_i,
    input  logic       zero_flag_i,
    input  logic       carry_i,
    input  logic       overflow_i,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic       cond_valid_i,
    input  logic [3:0] cond_i,
    output logic [3:0] nzcv_o,
    output logic       taken_valid_o,
    output logic       branch_taken_o,
    output logic       cond_err_o
);

    nzcv_t r_nzcv;
    logic  r_taken_valid;
    logic  r_branch_taken;
    logic  r_cond_err;

    nzcv_t w_in_flags;
    nzcv_t w_eval_flags;
    cond_e w_cond;
    logic  w_taken;
    logic  w_accept;

    assign w_in_flags = '{n: negative_i, z: zero_flag_i, c: carry_i, v: overflow_i};
    assign w_cond     = cond_e'(cond_i);
    assign w_accept   = cond_valid_i && !stall_i && !flush_i;

    // Without bypass a request in a write cycle sees the old flags while the
    // new ones land on the same edge.
    assign w_eval_flags = (BYPASS && write_flags_i) ? w_in_flags : r_nzcv;

    cond_eval u_cond_eval (
        .i_flags (w_eval_flags),
        .i_cond  (w_cond),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nzcv         <= nzcv_t'(RESET_NZCV);
            r_taken_valid  <= 1'b0;
            r_branch_taken <= 1'b0;
            r_cond_err     <= 1'b0;
        end else if (!stall_i) begin
            if (write_flags_i) begin
                r_nzcv <= w_in_flags;
            end
            r_taken_valid <= w_accept;
            // Decision holds its last value when no request is accepted.
            if (w_accept) begin
                r_branch_taken <= w_taken;
                if (w_cond == COND_NV) begin
                    r_cond_err <= 1'b1;
                end
            end
        end
    end

    assign nzcv_o         = r_nzcv;
    assign taken_valid_o  = r_taken_valid;
    assign branch_taken_o = r_branch_taken;
    assign cond_err_o     = r_cond_err;

endmodule
